jesd_tx_link_sequencer: RTL
===========================

# jesd_tx_link_sequencer

JESD204B transmit data-link-layer sequencer sitting between the transport-layer framer and the per-lane 8b/10b encoders. It runs the link bring-up:
- Code Group Synchronization (CGS): /K/ characters while SYNC~ is low.
- Initial Lane Alignment Sequence (ILAS): four multiframes aligned to the local multiframe clock (LMFC).
- User data: passes framed transport data through, with K-character flags for the encoder.

## Interface
- DATA_WIDTH, 64: total octet bus width; 2 octets per lane per clock (DATA_WIDTH = 16*LANES).
- LANES, 4: number of lanes.
- F, 2: octets per frame.
- K, 16: frames per multiframe; F*K must be even.
- ILAS_MF, 4: ILAS length in multiframes.
- clock  in  1  single design clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sync_n  in  1  SYNC~ from receiver, synchronous to clock; low = request resync.
- tx_datain  in  DATA_WIDTH  framed octets from transport layer.
- ilas_cfg  in  112  14 link-configuration octets; octet 0 is bits [111:104].
- tx_ready  out  1  high when tx_datain is being consumed (DATA state).
- tx_data  out  DATA_WIDTH  octets to 8b/10b encoders.
- tx_charisk  out  DATA_WIDTH/8  per-octet K-character flag.
- link_state  out  2  0 = CGS, 1 = ILAS, 2 = DATA.
- lmfc_edge  out  1  pulses on the first cycle of each multiframe.

## Operation
- Lane l uses tx_data[16l+15:16l]. Octet sent first in time is [15:8]; matching flag is tx_charisk[2l+1].
- MF_CYC = F*K/2 cycles per multiframe.
- LMFC counter:
  - lmfc_cnt runs 0..MF_CYC-1 and wraps.
  - Free-running from reset release, unaffected by state changes.
  - lmfc_edge = (lmfc_cnt == 0).
- CGS:
  - All octets are /K/ 0xBC with charisk = 1.
  - Exit to ILAS when sync_n is sampled high in the cycle where lmfc_cnt == MF_CYC-1.
  - sync_n rising at any other time waits for that boundary.
- ILAS: ILAS_MF multiframes, mf_idx 0..ILAS_MF-1; octet index o = 2*lmfc_cnt + {0,1}. All lanes are identical except the LID octet.
  - o = 0: /R/ 0x1C, charisk 1.
  - o = 2*MF_CYC-1: /A/ 0x7C, charisk 1.
  - mf_idx 1, o = 1: /Q/ 0x9C, charisk 1.
  - mf_idx 1, o = 2..15: ilas_cfg octet (o-2), charisk 0. Config octet 3 (LID) has bits [4:0] replaced by lane index l.
  - All other octets: ramp value o[7:0], charisk 0.
  - After the /A/ cycle of mf_idx ILAS_MF-1, enter DATA.
- DATA:
  - tx_data = tx_datain registered one cycle; charisk = 0; tx_ready = 1.
- Resync: sync_n low in ILAS or DATA returns the block to CGS on the next cycle. mf_idx clears.
- Reset:
  - State CGS, lmfc_cnt 0, mf_idx 0.
  - tx_data 0, tx_charisk 0, tx_ready 0, link_state 0, lmfc_edge 0.
  - Reset is asserted asynchronously at any time and aborts ILAS/DATA mid-multiframe.

## Timing
- All outputs are registered.
- State change decided in cycle n appears on outputs in cycle n+1.
- Latency tx_datain -> tx_data: 1 cycle. tx_ready is high in the same cycle that tx_datain is captured.
- First cycle after reset release: /K/ on all octets, link_state 0, lmfc_edge 1.
- CGS->ILAS: first ILAS output cycle has lmfc_cnt 0, with /R/ on octet 0 of every lane.
- ILAS duration: exactly ILAS_MF*MF_CYC cycles (default 64). DATA begins on an LMFC boundary.
- sync_n low in the last ILAS cycle: CGS wins; no DATA cycle is emitted.
- sync_n high again in the same cycle that CGS is entered: wait for the next boundary, then run a full ILAS.

## Structure
- Shared package jesd_pkg holds:
  - K-character constants: K28_5 0xBC, K28_0 0x1C, K28_3 0x7C, K28_4 0x9C.
  - link_state encoding.
  - Config octet index of LID (3).
- One sub-module, jesd_lmfc_counter: parameter MF_CYC; outputs lmfc_cnt and lmfc_edge.
- Sequencer FSM and per-lane octet muxing live in a generate loop in the top of this block.

## Test plan
- Reset low 3 cycles, sync_n low -> outputs 0 during reset, then every octet 0xBC with charisk all 1, link_state 0, for 40 cycles.
- Raise sync_n at lmfc_cnt = 5 (defaults) -> CGS continues through lmfc_cnt 15. ILAS starts at lmfc_cnt 0:
  - Lane 0 first cycle = 0x1C01, charisk 2'b10.
  - Cycle 15 = 0x1E7C, charisk 2'b01.
- ILAS multiframe 1 with ilas_cfg = 0x000102...0D:
  - Cycle 0 = 0x1C9C (both octets K).
  - Cycle 1 = 0x0001, charisk 0.
  - Lane 2 LID octet = 0x02.
  - DATA begins exactly 64 cycles after ILAS start.
- In DATA drive tx_datain = 'h12345678_abc, adding 'h11111111_111 each cycle -> tx_data equals tx_datain delayed 1 cycle, charisk 0, tx_ready 1.
- Drop sync_n mid-ILAS (mf_idx 2, lmfc_cnt 7) and mid-DATA -> 0xBC on all octets the next cycle, tx_ready 0, mf_idx restarts at 0 on the next ILAS.
- Assert reset during DATA, between clock edges -> outputs 0 immediately. After release, CGS with lmfc_cnt restarting at 0.

Source files
------------

// File: rtl/jesd_pkg.sv
// Shared constants and types for the JESD204B transmit link-layer sequencer.
package jesd_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;   // /K/ code group sync
   localparam logic [7:0] K28_0 = 8'h1C;   // /R/ multiframe start
   localparam logic [7:0] K28_3 = 8'h7C;   // /A/ multiframe end
   localparam logic [7:0] K28_4 = 8'h9C;   // /Q/ config follows

   localparam int CFG_OCTETS = 14;
   localparam int LID_OCTET  = 3;

   typedef enum logic [1:0] {
      LS_CGS  = 2'd0,
      LS_ILAS = 2'd1,
      LS_DATA = 2'd2
   } link_state_t;

   typedef struct packed {
      logic       k;
      logic [7:0] data;
   } octet_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // ILAS octet o of multiframe mf for a given lane; cfg octet 0 sits in bits [111:104].
   function automatic octet_t ilas_octet(input int o, input int mf, input int lane,
                                         input int mf_cyc, input logic [111:0] cfg);
      octet_t       r;
      logic [111:0] shifted;
      logic [7:0]   c;
      r.k     = 1'b0;
      r.data  = 8'(o);
      shifted = '0;
      c       = 8'h00;
      if (o == 0) begin
         r.k    = 1'b1;
         r.data = K28_0;
      end else if (o == 2 * mf_cyc - 1) begin
         r.k    = 1'b1;
         r.data = K28_3;
      end else if (mf == 1 && o == 1) begin
         r.k    = 1'b1;
         r.data = K28_4;
      end else if (mf == 1 && o >= 2 && o < 2 + CFG_OCTETS) begin
         shifted = cfg << (8 * (o - 2));
         c       = shifted[111:104];
         if (o - 2 == LID_OCTET) begin
            c[4:0] = 5'(lane);
         end
         r.data = c;
      end
      return r;
   endfunction

endpackage

// File: rtl/jesd_lmfc_counter.sv
// Local multiframe clock counter: free-running 0..MF_CYC-1 from reset release.
module jesd_lmfc_counter
   import jesd_pkg::*;
#(
   parameter int MF_CYC = 16,
   parameter int CNT_W  = cnt_width(MF_CYC)
)(
   input  logic             clock,
   input  logic             reset,
   output logic [CNT_W-1:0] lmfc_cnt,
   output logic             lmfc_edge
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MF_CYC - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign lmfc_cnt  = cnt_reg;
   assign lmfc_edge = (cnt_reg == '0);

endmodule

// File: rtl/jesd_tx_link_sequencer.sv
// JESD204B transmit link sequencer: CGS -> ILAS -> DATA, aligned to the LMFC,
// with per-lane octet muxing and K-character flags for the 8b/10b encoders.
module jesd_tx_link_sequencer
   import jesd_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int LANES      = 4,
   parameter int F          = 2,
   parameter int K          = 16,
   parameter int ILAS_MF    = 4
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    sync_n,
   input  logic [DATA_WIDTH-1:0]   tx_datain,
   input  logic [111:0]            ilas_cfg,
   output logic                    tx_ready,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic [DATA_WIDTH/8-1:0] tx_charisk,
   output logic [1:0]              link_state,
   output logic                    lmfc_edge
);

   localparam int MF_CYC = F * K / 2;
   localparam int CNT_W  = cnt_width(MF_CYC);
   localparam int MF_W   = cnt_width(ILAS_MF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MF_CYC - 1);
   localparam logic [MF_W-1:0]  MF_LAST  = MF_W'(ILAS_MF - 1);

   logic [CNT_W-1:0]        lmfc_cnt;
   logic                    cnt_edge;
   logic                    mf_last_cyc;

   link_state_t             state_reg;
   link_state_t             state_next;
   link_state_t             out_state;
   logic [MF_W-1:0]         mf_idx_reg;
   logic [MF_W-1:0]         mf_idx_next;

   logic [DATA_WIDTH-1:0]   tx_data_next;
   logic [DATA_WIDTH/8-1:0] charisk_next;
   logic [DATA_WIDTH-1:0]   tx_data_reg;
   logic [DATA_WIDTH/8-1:0] charisk_reg;
   logic                    tx_ready_reg;
   link_state_t             link_state_reg;
   logic                    lmfc_edge_reg;

   jesd_lmfc_counter #(
      .MF_CYC (MF_CYC),
      .CNT_W  (CNT_W)
   ) u_lmfc (
      .clock     (clock),
      .reset     (reset),
      .lmfc_cnt  (lmfc_cnt),
      .lmfc_edge (cnt_edge)
   );

   assign mf_last_cyc = (lmfc_cnt == CNT_LAST);

   // State, multiframe index and all output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= LS_CGS;
         mf_idx_reg     <= '0;
         tx_data_reg    <= '0;
         charisk_reg    <= '0;
         tx_ready_reg   <= 1'b0;
         link_state_reg <= LS_CGS;
         lmfc_edge_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mf_idx_reg     <= mf_idx_next;
         tx_data_reg    <= tx_data_next;
         charisk_reg    <= charisk_next;
         tx_ready_reg   <= (state_next == LS_DATA);
         link_state_reg <= out_state;
         lmfc_edge_reg  <= cnt_edge;
      end
   end

   always_comb begin
      state_next  = state_reg;
      mf_idx_next = mf_idx_reg;
      case (state_reg)
         LS_CGS: begin
            if (sync_n && mf_last_cyc) begin
               state_next = LS_ILAS;
            end
         end
         LS_ILAS: begin
            if (!sync_n) begin
               state_next = LS_CGS;
            end else if (mf_last_cyc) begin
               if (mf_idx_reg == MF_LAST) begin
                  state_next = LS_DATA;
               end else begin
                  mf_idx_next = mf_idx_reg + 1'b1;
               end
            end
         end
         LS_DATA: begin
            if (!sync_n) begin
               state_next = LS_CGS;
            end
         end
         default: state_next = LS_CGS;
      endcase
      if (state_next != LS_ILAS) begin
         mf_idx_next = '0;
      end
   end

   // A resync request overrides the current cycle so /K/ appears one cycle later.
   always_comb begin
      out_state = state_reg;
      if (state_reg != LS_CGS && !sync_n) begin
         out_state = LS_CGS;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      octet_t      first_oct;
      octet_t      second_oct;
      logic [15:0] lane_data;
      logic [1:0]  lane_k;

      assign first_oct  = ilas_octet(2 * int'(lmfc_cnt), int'(mf_idx_reg), gi, MF_CYC, ilas_cfg);
      assign second_oct = ilas_octet(2 * int'(lmfc_cnt) + 1, int'(mf_idx_reg), gi, MF_CYC, ilas_cfg);

      always_comb begin
         lane_data = {K28_5, K28_5};
         lane_k    = 2'b11;
         case (out_state)
            LS_ILAS: begin
               lane_data = {first_oct.data, second_oct.data};
               lane_k    = {first_oct.k, second_oct.k};
            end
            LS_DATA: begin
               lane_data = tx_datain[16*gi +: 16];
               lane_k    = 2'b00;
            end
            default: ;
         endcase
      end

      assign tx_data_next[16*gi +: 16] = lane_data;
      assign charisk_next[2*gi +: 2]   = lane_k;
   end

   assign tx_data    = tx_data_reg;
   assign tx_charisk = charisk_reg;
   assign tx_ready   = tx_ready_reg;
   assign link_state = link_state_reg;
   assign lmfc_edge  = lmfc_edge_reg;

endmodule
